morphle_config_loader: RTL

// Wishbone-slave transmitter for the Morphle Logic configuration chain. Replaces manual
// bit-banging of reset/confclk/cbitin through the logic analyzer pins. The RISC-V

---
 rtl/morphle_config_loader.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/morphle_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : morphle_config_loader
// Description : Wishbone slave that queues Morphle Logic configuration rows
//               in a FIFO and shifts each one into the yblock with a timed
//               confclk strobe, capturing the row leaving the chain bottom.
// Revision    : 1.0 - initial release
// ============================================================================
module morphle_config_loader #(
  parameter int BLOCKWIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int HALF       = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cfg_reset,
  output logic                  confclk,
  output logic [BLOCKWIDTH-1:0] cbitin,
  input  logic [BLOCKWIDTH-1:0] cbitout,
  output logic                  busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(HALF - 1);
  localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(DEPTH);
  localparam logic [1:0] c_ADR_CTRL     = 2'd0;
  localparam logic [1:0] c_ADR_DATA     = 2'd1;
  localparam logic [1:0] c_ADR_STATUS   = 2'd2;
  localparam logic [1:0] c_ADR_READBACK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Registered state
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_cfg_reset;
  logic                  r_overflow;
  logic                  r_confclk;
  logic [BLOCKWIDTH-1:0] r_cbitin;
  logic [BLOCKWIDTH-1:0] r_readback;
  logic [BLOCKWIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;
  state_t                r_state;
  logic [c_PW-1:0]       r_phase;

  // Combinational
  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic [1:0]            w_adr;
  logic                  w_clr;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_overflow_set;
  logic                  w_overflow_clr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_phase_last;
  logic [BLOCKWIDTH-1:0] w_head;
  state_t                w_state_nxt;
  logic [31:0]           w_status;
  logic [31:0]           w_readback_ext;
  logic [31:0]           w_rdata;
  logic                  w_unused_bits;

  // Address bits outside [3:2], upper selects and unused data bits are ignored.
  assign w_unused_bits = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i};

  assign w_req = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr  = w_req & wbs_we_i;
  assign w_rd  = w_req & ~wbs_we_i;
  assign w_adr = wbs_adr_i[3:2];

  assign w_full       = (r_count == c_FULL_COUNT);
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_phase_last = (r_phase == c_PHASE_LAST);

  // Clear takes priority over any push arriving in the same cycle.
  assign w_clr          = w_wr & (w_adr == c_ADR_CTRL) & wbs_dat_i[1];
  assign w_push_req     = w_wr & (w_adr == c_ADR_DATA) & (wbs_sel_i[1:0] == 2'b11) & ~w_clr;
  // A push into a full FIFO is still accepted when a pop frees the slot.
  assign w_push         = w_push_req & (~w_full | w_pop);
  assign w_overflow_set = w_push_req & w_full & ~w_pop;
  assign w_overflow_clr = w_wr & (w_adr == c_ADR_STATUS) & wbs_dat_i[11];

  assign busy      = (r_state != S_IDLE) | ~w_empty;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign cfg_reset = r_cfg_reset;
  assign confclk   = r_confclk;
  assign cbitin    = r_cbitin;

  // Row storage; contents are don't-care until written.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wbs_dat_i[BLOCKWIDTH-1:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state register and per-phase cycle counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  // Sequencer next state; a pop happens on leaving IDLE or at the end of HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !w_clr) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_phase_last) w_state_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (w_phase_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_phase_last) begin
          if (!w_empty && !w_clr) begin
            w_pop       = 1'b1;
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe, row and readback registers; confclk follows the next state so it is a clean flop output.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_confclk  <= 1'b0;
      r_cbitin   <= '0;
      r_readback <= '0;
    end else begin
      r_confclk <= (w_state_nxt == S_HIGH);
      if (w_pop) r_cbitin <= w_head;
      if ((r_state == S_HIGH) && (r_phase == '0)) r_readback <= cbitout;
    end
  end

  // Read data multiplexer.
  always_comb begin
    w_status          = '0;
    w_status[7:0]     = 8'(r_count);
    w_status[8]       = busy;
    w_status[9]       = w_full;
    w_status[10]      = w_empty;
    w_status[11]      = r_overflow;
    w_readback_ext    = '0;
    w_readback_ext[BLOCKWIDTH-1:0] = r_readback;
    case (w_adr)
      c_ADR_CTRL:     w_rdata = {31'd0, r_cfg_reset};
      c_ADR_STATUS:   w_rdata = w_status;
      c_ADR_READBACK: w_rdata = w_readback_ext;
      default:        w_rdata = '0;
    endcase
  end

  // Wishbone handshake, control register and sticky overflow flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_cfg_reset <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_wr && (w_adr == c_ADR_CTRL)) r_cfg_reset <= wbs_dat_i[0];
      if (w_overflow_clr) begin
        r_overflow <= 1'b0;
      end else if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
